// File: rtl/updown_pkg.sv
// Shared encodings for the up/down direction controller.
// Direction, mode and FSM state definitions.
package updown_pkg;

  localparam logic DIR_UP      = 1'b1;
  localparam logic DIR_DOWN    = 1'b0;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  typedef enum logic {
    ST_DOWN = 1'b0,
    ST_UP   = 1'b1
  } dir_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchroniser and debouncer.
// Emits a one-cycle press pulse on a filtered 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          settle;

  // last differing sample needed to accept the new level
  assign settle = (sync2 != level) && (cnt == LAST);

  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // count consecutive samples that disagree with the level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sync2 == level || settle) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // accept the new level; flag only the rising acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= settle && sync2;
      if (settle) begin
        level <= sync2;
      end
    end
  end

endmodule

// File: rtl/updown_ctrl.sv
// Direction controller for the up/down counter.
// UPDOWN_CTRL_BOUNCE_EN adds the mode button and end-of-range bounce.
module updown_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_dir,
  input  logic             btn_mode,
  input  logic [WIDTH-1:0] count,
  output logic             updown,
  output logic             mode,
  output logic             dir_changed
);

  localparam logic [WIDTH-1:0] MAX = '1;

  dir_state_t state;
  dir_state_t state_nx;
  logic       chg_nx;
  logic       dir_level;
  logic       dir_press;
  logic       trigger;
  logic       toggle;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dir (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_dir),
    .level(dir_level),
    .press(dir_press)
  );

`ifdef UPDOWN_CTRL_BOUNCE_EN
  logic mode_level;
  logic mode_press;
  logic mode_q;
  logic unused_lvl;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_mode),
    .level(mode_level),
    .press(mode_press)
  );

  // mode toggles on each debounced mode press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_MANUAL;
    end else if (mode_press) begin
      mode_q <= ~mode_q;
    end
  end

  // one step early so the flip lands as the counter hits the end;
  // muted right after a flip to avoid a double toggle
  assign trigger = (mode_q == MODE_BOUNCE) && !dir_changed &&
                   ((state == ST_UP) ? (count >= MAX - 1'b1)
                                     : (count <= WIDTH'(1)));
  assign mode       = mode_q;
  assign unused_lvl = dir_level ^ mode_level;
`else
  logic unused_in;

  assign trigger   = 1'b0;
  assign mode      = MODE_MANUAL;
  assign unused_in = ^{btn_mode, count, dir_level};
`endif

  assign toggle = dir_press || trigger;
  assign updown = (state == ST_UP) ? DIR_UP : DIR_DOWN;

  // direction state and change pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_UP;
      dir_changed <= 1'b0;
    end else begin
      state       <= state_nx;
      dir_changed <= chg_nx;
    end
  end

  // any toggle request flips once, however many sources fire
  always_comb begin
    state_nx = state;
    chg_nx   = 1'b0;
    if (toggle) begin
      chg_nx = 1'b1;
      unique case (state)
        ST_UP:   state_nx = ST_DOWN;
        ST_DOWN: state_nx = ST_UP;
        default: state_nx = ST_UP;
      endcase
    end
  end

endmodule
